// File: rtl/vmem_arbiter.sv
// vmem_arbiter: two-port round-robin arbiter and sequencer for the 512-bit vector data memory.
// Each accepted request becomes one ISSUE strobe, one CAPT cycle, then a one-cycle response.
module vmem_arbiter #(
  parameter int DATA_W     = 512,
  parameter int ADDR_W     = 9,
  parameter int WORDS      = 16,
  parameter int ALLOW_WRAP = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic              req0_we,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_wdata,
  output logic              rsp0_valid,
  output logic              rsp0_err,
  output logic [DATA_W-1:0] rsp0_rdata,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic              req1_we,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_wdata,
  output logic              rsp1_valid,
  output logic              rsp1_err,
  output logic [DATA_W-1:0] rsp1_rdata,
  output logic              mem_write_en,
  output logic              mem_read_en,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_write_data,
  input  logic [DATA_W-1:0] mem_read_data,
  output logic              busy
);
  typedef enum logic [1:0] {IDLE, ISSUE, CAPT} state_t;
  localparam logic [ADDR_W:0] LAST = (ADDR_W+1)'(2**ADDR_W - WORDS);
  state_t state, state_nx;
  logic last_grant, grant, accept, owner, we, err;
  logic [ADDR_W-1:0] addr, sel_addr;
  logic [DATA_W-1:0] wdata;
  logic done0, done1;
  // with both ports valid, the port that did not win last time is granted
  assign grant      = (req0_valid && req1_valid) ? ~last_grant : req1_valid;
  assign req0_ready = (state == IDLE) && req0_valid && !grant;
  assign req1_ready = (state == IDLE) && req1_valid && grant;
  assign accept     = req0_ready || req1_ready;
  assign sel_addr   = grant ? req1_addr : req0_addr;
  assign busy       = state != IDLE;
  assign mem_address    = addr;
  assign mem_write_data = wdata;
  assign done0 = (state == CAPT) && !owner;
  assign done1 = (state == CAPT) && owner;
  always_ff @(posedge clk or negedge reset)
    if (!reset) state <= IDLE;
    else state <= state_nx;
  // strobes decode from the state register so an async reset drops them at once
  always_comb begin
    state_nx     = state;
    mem_write_en = 1'b0;
    mem_read_en  = 1'b0;
    case (state)
      IDLE:  state_nx = accept ? ISSUE : IDLE;
      ISSUE: begin
        state_nx     = CAPT;
        mem_write_en = !err && we;
        mem_read_en  = !err && !we;
      end
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      last_grant <= 1'b1;
      owner      <= 1'b0;
      we         <= 1'b0;
      err        <= 1'b0;
      addr       <= '0;
      wdata      <= '0;
      rsp0_valid <= 1'b0;
      rsp0_err   <= 1'b0;
      rsp0_rdata <= '0;
      rsp1_valid <= 1'b0;
      rsp1_err   <= 1'b0;
      rsp1_rdata <= '0;
    end else begin
      if (accept) begin
        owner      <= grant;
        last_grant <= grant;
        we         <= grant ? req1_we : req0_we;
        addr       <= sel_addr;
        wdata      <= grant ? req1_wdata : req0_wdata;
        err        <= (ALLOW_WRAP == 0) && ({1'b0, sel_addr} > LAST);
      end
      rsp0_valid <= done0;
      rsp0_err   <= done0 && err;
      rsp1_valid <= done1;
      rsp1_err   <= done1 && err;
      if (done0 && !we && !err) rsp0_rdata <= mem_read_data;
      if (done1 && !we && !err) rsp1_rdata <= mem_read_data;
    end
endmodule

// File: tb/tb_vmem_arbiter.sv
// tb_vmem_arbiter: directed scenarios for vmem_arbiter against a behavioural 512x32 memory;
// a second instance with wrapping enabled covers the cross-boundary load.
module tb_vmem_arbiter;
  localparam int DW = 512;
  localparam int AW = 9;
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;
  logic          req0_valid, req0_ready, req0_we, rsp0_valid, rsp0_err;
  logic [AW-1:0] req0_addr;
  logic [DW-1:0] req0_wdata, rsp0_rdata;
  logic          req1_valid, req1_ready, req1_we, rsp1_valid, rsp1_err;
  logic [AW-1:0] req1_addr;
  logic [DW-1:0] req1_wdata, rsp1_rdata;
  logic          mem_write_en, mem_read_en, busy;
  logic [AW-1:0] mem_address;
  logic [DW-1:0] mem_write_data, mem_read_data;
  logic          w_req0_ready, w_rsp0_valid, w_rsp0_err;
  logic [DW-1:0] w_rsp0_rdata;
  logic          w_req1_valid, w_req1_ready, w_rsp1_valid, w_rsp1_err;
  logic [DW-1:0] w_rsp1_rdata;
  logic          w_mem_write_en, w_mem_read_en, w_busy;
  logic [AW-1:0] w_mem_address;
  logic [DW-1:0] w_mem_write_data, w_mem_read_data;
  int vectors = 0;
  int errors = 0;
  logic [31:0] mem [512];

  vmem_arbiter #(.ALLOW_WRAP(0)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_we(req0_we), .req0_addr(req0_addr),
    .req0_wdata(req0_wdata), .rsp0_valid(rsp0_valid), .rsp0_err(rsp0_err), .rsp0_rdata(rsp0_rdata),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_we(req1_we), .req1_addr(req1_addr),
    .req1_wdata(req1_wdata), .rsp1_valid(rsp1_valid), .rsp1_err(rsp1_err), .rsp1_rdata(rsp1_rdata),
    .mem_write_en(mem_write_en), .mem_read_en(mem_read_en), .mem_address(mem_address),
    .mem_write_data(mem_write_data), .mem_read_data(mem_read_data), .busy(busy)
  );

  vmem_arbiter #(.ALLOW_WRAP(1)) u_wrap (
    .clk(clk), .reset(reset),
    .req0_valid(1'b0), .req0_ready(w_req0_ready), .req0_we(1'b0), .req0_addr(9'd0),
    .req0_wdata('0), .rsp0_valid(w_rsp0_valid), .rsp0_err(w_rsp0_err), .rsp0_rdata(w_rsp0_rdata),
    .req1_valid(w_req1_valid), .req1_ready(w_req1_ready), .req1_we(1'b0), .req1_addr(9'd497),
    .req1_wdata('0), .rsp1_valid(w_rsp1_valid), .rsp1_err(w_rsp1_err), .rsp1_rdata(w_rsp1_rdata),
    .mem_write_en(w_mem_write_en), .mem_read_en(w_mem_read_en), .mem_address(w_mem_address),
    .mem_write_data(w_mem_write_data), .mem_read_data(w_mem_read_data), .busy(w_busy)
  );

  function automatic logic [31:0] f(int a);
    return 32'hA500_0000 | 32'(a & 511);
  endfunction

  // memory content starts as f(address); accesses wrap modulo 512 words
  always @(posedge clk or negedge reset)
    if (!reset) begin
      for (int i = 0; i < 512; i++) mem[i] <= f(i);
    end else begin
      if (mem_write_en)
        for (int i = 0; i < 16; i++) mem[9'(mem_address + 9'(i))] <= mem_write_data[32*i +: 32];
      if (mem_read_en)
        for (int i = 0; i < 16; i++) mem_read_data[32*i +: 32] <= mem[9'(mem_address + 9'(i))];
    end

  always @(posedge clk)
    if (w_mem_read_en)
      for (int i = 0; i < 16; i++) w_mem_read_data[32*i +: 32] <= f(int'(w_mem_address) + i);

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b0;
    repeat (3) tick;
    vectors++;
    if ({mem_write_en, mem_read_en, busy, rsp0_valid, rsp0_err, rsp1_valid, rsp1_err} !== 7'b0) begin
      errors++;
      $display("FAIL reset_flags: got %b want 0000000", {mem_write_en, mem_read_en, busy, rsp0_valid, rsp0_err, rsp1_valid, rsp1_err});
    end
    vectors++;
    if (mem_address !== 9'd0 || (mem_write_data | rsp0_rdata | rsp1_rdata) !== '0) begin
      errors++;
      $display("FAIL reset_data: mem_address %h, data/rdata nonzero, want all zero", mem_address);
    end
    #2 reset = 1'b1;
    tick;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    #1;
    vectors++;
    if ({req0_ready, req1_ready} !== 2'b10) begin
      errors++;
      $display("FAIL reset_first_grant: got ready %b want 10", {req0_ready, req1_ready});
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
  endtask

  task automatic test_store_load;
    logic [DW-1:0] wd;
    for (int i = 0; i < 16; i++) wd[32*i +: 32] = 32'(i + 1);
    tick;
    req0_valid = 1'b1; req0_we = 1'b1; req0_addr = 9'h020; req0_wdata = wd;
    #1;
    vectors++;
    if ({req0_ready, req1_ready, busy} !== 3'b100) begin
      errors++;
      $display("FAIL store_accept: got %b want 100", {req0_ready, req1_ready, busy});
    end
    tick;
    req0_valid = 1'b0;
    vectors++;
    if ({mem_write_en, mem_read_en, busy, req0_ready} !== 4'b1010 || mem_address !== 9'h020) begin
      errors++;
      $display("FAIL store_issue: got %b addr %h want 1010 addr 020", {mem_write_en, mem_read_en, busy, req0_ready}, mem_address);
    end
    vectors++;
    if (mem_write_data !== wd) begin
      errors++;
      $display("FAIL store_wdata: got %h want %h", mem_write_data, wd);
    end
    tick;
    vectors++;
    if ({mem_write_en, mem_read_en, busy} !== 3'b001) begin
      errors++;
      $display("FAIL store_capt: got %b want 001", {mem_write_en, mem_read_en, busy});
    end
    tick;
    vectors++;
    if ({rsp0_valid, rsp0_err, rsp1_valid, busy} !== 4'b1000) begin
      errors++;
      $display("FAIL store_rsp: got %b want 1000", {rsp0_valid, rsp0_err, rsp1_valid, busy});
    end
    req0_valid = 1'b1; req0_we = 1'b0;
    #1;
    vectors++;
    if (req0_ready !== 1'b1) begin
      errors++;
      $display("FAIL load_accept: got %b want 1", req0_ready);
    end
    tick;
    req0_valid = 1'b0;
    vectors++;
    if ({mem_write_en, mem_read_en} !== 2'b01) begin
      errors++;
      $display("FAIL load_issue: got %b want 01", {mem_write_en, mem_read_en});
    end
    tick;
    tick;
    vectors++;
    if ({rsp0_valid, rsp0_err} !== 2'b10 || rsp0_rdata !== wd) begin
      errors++;
      $display("FAIL load_rsp: got %b data %h want 10 data %h", {rsp0_valid, rsp0_err}, rsp0_rdata, wd);
    end
    tick;
    vectors++;
    if (rsp0_valid !== 1'b0 || rsp0_rdata !== wd) begin
      errors++;
      $display("FAIL load_rsp_pulse: got valid %b, rdata held %b; want 0, 1", rsp0_valid, rsp0_rdata === wd);
    end
  endtask

  task automatic test_round_robin;
    req0_we = 1'b0; req0_addr = 9'h000;
    req1_we = 1'b0; req1_addr = 9'h100;
    req0_valid = 1'b1; req1_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      logic e;
      e = (k % 2 == 0);
      #1;
      vectors++;
      if ({req1_ready, req0_ready} !== {e, !e}) begin
        errors++;
        $display("FAIL rr_grant k=%0d: got %b want %b", k, {req1_ready, req0_ready}, {e, !e});
      end
      tick;
      vectors++;
      if ({mem_read_en, mem_write_en, busy, req0_ready, req1_ready} !== 5'b10100 || mem_address !== (e ? 9'h100 : 9'h000)) begin
        errors++;
        $display("FAIL rr_issue k=%0d: got %b addr %h", k, {mem_read_en, mem_write_en, busy, req0_ready, req1_ready}, mem_address);
      end
      tick;
      vectors++;
      if ({busy, req0_ready, req1_ready} !== 3'b100) begin
        errors++;
        $display("FAIL rr_capt k=%0d: got %b want 100", k, {busy, req0_ready, req1_ready});
      end
      tick;
      vectors++;
      if ({rsp1_valid, rsp0_valid, busy} !== {e, !e, 1'b0}) begin
        errors++;
        $display("FAIL rr_rsp k=%0d: got %b want %b", k, {rsp1_valid, rsp0_valid, busy}, {e, !e, 1'b0});
      end
      vectors++;
      if ((e ? rsp1_rdata[31:0] : rsp0_rdata[31:0]) !== (e ? f(256) : f(0))) begin
        errors++;
        $display("FAIL rr_rdata k=%0d: got %h want %h", k, e ? rsp1_rdata[31:0] : rsp0_rdata[31:0], e ? f(256) : f(0));
      end
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
  endtask

  task automatic test_error;
    logic [DW-1:0] prev, wrapped;
    for (int i = 0; i < 16; i++) begin
      prev[32*i +: 32] = f(256 + i);
      wrapped[32*i +: 32] = f(497 + i);
    end
    req1_valid = 1'b1; req1_we = 1'b0; req1_addr = 9'd497;
    w_req1_valid = 1'b1;
    #1;
    vectors++;
    if ({req1_ready, w_req1_ready} !== 2'b11) begin
      errors++;
      $display("FAIL err_accept: got %b want 11", {req1_ready, w_req1_ready});
    end
    tick;
    req1_valid = 1'b0; w_req1_valid = 1'b0;
    vectors++;
    if ({mem_write_en, mem_read_en, busy} !== 3'b001) begin
      errors++;
      $display("FAIL err_no_strobe: got %b want 001", {mem_write_en, mem_read_en, busy});
    end
    vectors++;
    if ({w_mem_read_en, w_mem_write_en} !== 2'b10 || w_mem_address !== 9'd497) begin
      errors++;
      $display("FAIL wrap_issue: got %b addr %0d want 10 addr 497", {w_mem_read_en, w_mem_write_en}, w_mem_address);
    end
    tick;
    tick;
    vectors++;
    if ({rsp1_valid, rsp1_err, rsp0_valid} !== 3'b110 || rsp1_rdata !== prev) begin
      errors++;
      $display("FAIL err_rsp: got %b rdata %h want 110 rdata %h", {rsp1_valid, rsp1_err, rsp0_valid}, rsp1_rdata, prev);
    end
    vectors++;
    if ({w_rsp1_valid, w_rsp1_err} !== 2'b10 || w_rsp1_rdata !== wrapped) begin
      errors++;
      $display("FAIL wrap_rsp: got %b rdata %h want 10 rdata %h", {w_rsp1_valid, w_rsp1_err}, w_rsp1_rdata, wrapped);
    end
  endtask

  task automatic test_last_legal;
    logic [DW-1:0] exp;
    for (int i = 0; i < 16; i++) exp[32*i +: 32] = f(496 + i);
    req0_valid = 1'b1; req0_we = 1'b0; req0_addr = 9'd496;
    tick;
    req0_valid = 1'b0;
    vectors++;
    if ({mem_read_en, mem_write_en} !== 2'b10 || mem_address !== 9'd496) begin
      errors++;
      $display("FAIL last_issue: got %b addr %0d want 10 addr 496", {mem_read_en, mem_write_en}, mem_address);
    end
    tick;
    tick;
    vectors++;
    if ({rsp0_valid, rsp0_err} !== 2'b10 || rsp0_rdata !== exp) begin
      errors++;
      $display("FAIL last_rsp: got %b rdata %h want 10 rdata %h", {rsp0_valid, rsp0_err}, rsp0_rdata, exp);
    end
  endtask

  task automatic test_reset_mid;
    req1_valid = 1'b1; req1_we = 1'b1; req1_addr = 9'h080; req1_wdata = '1;
    tick;
    req1_valid = 1'b0;
    vectors++;
    if (mem_write_en !== 1'b1) begin
      errors++;
      $display("FAIL mid_issue: got write_en %b want 1", mem_write_en);
    end
    #2 reset = 1'b0;
    #1;
    vectors++;
    if ({mem_write_en, mem_read_en, busy} !== 3'b000) begin
      errors++;
      $display("FAIL mid_async_drop: got %b want 000", {mem_write_en, mem_read_en, busy});
    end
    tick;
    tick;
    vectors++;
    if ({rsp1_valid, mem_write_en, mem_read_en} !== 3'b000) begin
      errors++;
      $display("FAIL mid_held: got %b want 000", {rsp1_valid, mem_write_en, mem_read_en});
    end
    #2 reset = 1'b1;
    tick;
    vectors++;
    if ({rsp1_valid, busy, mem_write_en} !== 3'b000) begin
      errors++;
      $display("FAIL mid_release: got %b want 000", {rsp1_valid, busy, mem_write_en});
    end
    req0_valid = 1'b1; req0_we = 1'b0; req0_addr = 9'h010;
    req1_valid = 1'b1; req1_we = 1'b0; req1_addr = 9'h011;
    #1;
    vectors++;
    if ({req0_ready, req1_ready} !== 2'b10) begin
      errors++;
      $display("FAIL mid_first_grant: got %b want 10", {req0_ready, req1_ready});
    end
    tick;
    req0_valid = 1'b0; req1_valid = 1'b0;
    tick;
    tick;
    vectors++;
    if ({rsp0_valid, rsp1_valid} !== 2'b10 || rsp0_rdata[31:0] !== f(16)) begin
      errors++;
      $display("FAIL mid_rsp: got %b word0 %h want 10 word0 %h", {rsp0_valid, rsp1_valid}, rsp0_rdata[31:0], f(16));
    end
  endtask

  task automatic test_back_to_back;
    req0_valid = 1'b1; req0_we = 1'b0; req0_addr = 9'h040;
    tick;
    req0_valid = 1'b0;
    tick;
    tick;
    req1_valid = 1'b1; req1_we = 1'b0; req1_addr = 9'h050;
    #1;
    vectors++;
    if ({rsp0_valid, req1_ready, req0_ready} !== 3'b110) begin
      errors++;
      $display("FAIL b2b_accept: got %b want 110", {rsp0_valid, req1_ready, req0_ready});
    end
    tick;
    req1_valid = 1'b0;
    vectors++;
    if ({mem_read_en, mem_write_en} !== 2'b10 || mem_address !== 9'h050) begin
      errors++;
      $display("FAIL b2b_issue: got %b addr %h want 10 addr 050", {mem_read_en, mem_write_en}, mem_address);
    end
    tick;
    tick;
    vectors++;
    if ({rsp1_valid, rsp1_err, rsp0_valid} !== 3'b100 || rsp1_rdata[31:0] !== f(80)) begin
      errors++;
      $display("FAIL b2b_rsp: got %b word0 %h want 100 word0 %h", {rsp1_valid, rsp1_err, rsp0_valid}, rsp1_rdata[31:0], f(80));
    end
  endtask

  initial begin
    req0_valid = 1'b0; req0_we = 1'b0; req0_addr = '0; req0_wdata = '0;
    req1_valid = 1'b0; req1_we = 1'b0; req1_addr = '0; req1_wdata = '0;
    w_req1_valid = 1'b0;
    test_reset;
    test_store_load;
    test_round_robin;
    test_error;
    test_last_legal;
    test_reset_mid;
    test_back_to_back;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
